// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory port.
// Requests are latched on grant; ties alternate, starting with the data side.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        iren,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dren,
    input  logic        dwen,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [2:0]  dwidth,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    output logic [2:0]  mem_width,
    input  logic        mem_ready,
    input  logic [31:0] mem_load,
    output logic        err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] I_ACC = 2'd1;
    localparam logic [1:0] D_ACC = 2'd2;
    // The counter holds the number of stalled cycles before the current one.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  state, state_nxt;
    logic        last_d;
    logic [7:0]  wait_cnt;
    logic [31:0] req_addr, req_store;
    logic [2:0]  req_width;
    logic        req_write;
    logic        d_req, grant_i, grant_d, acc, timeout;

    assign d_req   = dren | dwen;
    assign grant_d = (state == IDLE) && d_req && (!iren || !last_d);
    assign grant_i = (state == IDLE) && iren && !grant_d;
    assign acc     = (state != IDLE);
    assign timeout = acc && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        if (grant_d)
            state_nxt = D_ACC;
        else if (grant_i)
            state_nxt = I_ACC;
        else if (acc && (mem_ready || timeout))
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            wait_cnt  <= 8'd0;
            req_addr  <= 32'd0;
            req_store <= 32'd0;
            req_width <= 3'd0;
            req_write <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                req_addr  <= daddr;
                req_store <= dstore;
                req_width <= dwidth;
                req_write <= dwen;
                last_d    <= 1'b1;
                wait_cnt  <= 8'd0;
            end else if (grant_i) begin
                req_addr  <= iaddr;
                req_store <= 32'd0;
                req_width <= 3'b010;
                req_write <= 1'b0;
                last_d    <= 1'b0;
                wait_cnt  <= 8'd0;
            end else if (acc && !mem_ready) begin
                wait_cnt  <= wait_cnt + 8'd1;
            end
        end
    end

    // Memory side is driven only from the latched request, gated by state.
    assign mem_ren   = acc && !req_write;
    assign mem_wen   = acc && req_write;
    assign mem_addr  = acc ? req_addr  : 32'd0;
    assign mem_store = acc ? req_store : 32'd0;
    assign mem_width = acc ? req_width : 3'd0;

    assign ihit  = (state == I_ACC) && mem_ready;
    assign dhit  = (state == D_ACC) && mem_ready;
    assign iload = ihit ? mem_load : 32'd0;
    assign dload = (dhit && !req_write) ? mem_load : 32'd0;
    assign err   = timeout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each step drives inputs after a rising edge
// and checks the combinational outputs of that cycle.
module tb_mem_arbiter;
    logic        clk = 1'b0, nrst = 1'b0;
    logic        iren = 1'b0, dren = 1'b0, dwen = 1'b0, mem_ready = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, mem_load = '0;
    logic [2:0]  dwidth = '0;
    logic        ihit, dhit, mem_ren, mem_wen, err;
    logic [31:0] iload, dload, mem_addr, mem_store;
    logic [2:0]  mem_width;
    int          n_tot = 0, n_pass = 0;

    mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .nrst(nrst),
        .iren(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dwidth(dwidth),
        .dhit(dhit), .dload(dload),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_store(mem_store), .mem_width(mem_width),
        .mem_ready(mem_ready), .mem_load(mem_load), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, with a request already present
        iren = 1'b1; mem_ready = 1'b1;
        #3;
        chk("rst_ren", mem_ren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ihit", ihit, 0);
        chk("rst_err", err, 0);
        iren = 1'b0; mem_ready = 1'b0;
        #9 nrst = 1'b1;

        // single instruction read, ready on first access cycle
        tick(); iren = 1'b1; iaddr = 32'h100; #1;
        chk("i_idle_ren", mem_ren, 0);
        tick(); iren = 1'b0; mem_ready = 1'b1; mem_load = 32'h13; #1;
        chk("i_ren", mem_ren, 1);
        chk("i_addr", mem_addr, 32'h100);
        chk("i_width", mem_width, 3'b010);
        chk("i_hit", ihit, 1);
        chk("i_load", iload, 32'h13);
        chk("i_nodhit", dhit, 0);
        tick(); #1;  // IDLE; mem_ready still high must be ignored
        chk("i_back_ren", mem_ren, 0);
        chk("idle_ready_ihit", ihit, 0);
        chk("idle_ready_iload", iload, 0);

        // tie alternation from reset: D, I, D
        mem_ready = 1'b0;
        nrst = 1'b0; #1 nrst = 1'b1;
        iren = 1'b1; iaddr = 32'h100; dren = 1'b1; daddr = 32'h2000; #1;
        tick(); mem_ready = 1'b1; mem_load = 32'hAA55; #1;
        chk("tie1_addr", mem_addr, 32'h2000);
        chk("tie1_dhit", dhit, 1);
        chk("tie1_dload", dload, 32'hAA55);
        chk("tie1_noihit", ihit, 0);
        tick(); mem_ready = 1'b0; #1;
        chk("tie1_idle", mem_ren, 0);
        tick(); mem_ready = 1'b1; mem_load = 32'h13; #1;
        chk("tie2_addr", mem_addr, 32'h100);
        chk("tie2_ihit", ihit, 1);
        chk("tie2_nodhit", dhit, 0);
        tick(); mem_ready = 1'b0; #1;
        tick(); mem_ready = 1'b1; #1;
        chk("tie3_addr", mem_addr, 32'h2000);
        chk("tie3_dhit", dhit, 1);
        tick(); iren = 1'b0; dren = 1'b0; mem_ready = 1'b0; #1;

        // data write with two stall cycles
        dwen = 1'b1; daddr = 32'h2000; dstore = 32'hDEADBEEF; dwidth = 3'd2; #1;
        tick(); dwen = 1'b0; dstore = 32'h0; #1;
        chk("w1_wen", mem_wen, 1);
        chk("w1_ren", mem_ren, 0);
        chk("w1_store", mem_store, 32'hDEADBEEF);
        chk("w1_dhit", dhit, 0);
        tick(); #1;
        chk("w2_store", mem_store, 32'hDEADBEEF);
        tick(); mem_ready = 1'b1; mem_load = 32'h12345678; #1;
        chk("w3_wen", mem_wen, 1);
        chk("w3_dhit", dhit, 1);
        chk("w3_dload", dload, 0);
        chk("w3_width", mem_width, 3'd2);
        tick(); mem_ready = 1'b0; #1;
        chk("w_idle_wen", mem_wen, 0);
        chk("w_idle_store", mem_store, 0);

        // timeout after 4 stalled access cycles
        dren = 1'b1; daddr = 32'h300; dwidth = 3'd0; #1;
        tick(); dren = 1'b0; #1;
        chk("to1_err", err, 0);
        tick(); #1;
        tick(); #1;
        chk("to3_err", err, 0);
        tick(); #1;
        chk("to4_err", err, 1);
        chk("to4_dhit", dhit, 0);
        chk("to4_ren", mem_ren, 1);
        tick(); #1;
        chk("to5_ren", mem_ren, 0);
        chk("to5_err", err, 0);

        // ready on the would-be timeout cycle wins
        dren = 1'b1; #1;
        tick(); dren = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        tick(); mem_ready = 1'b1; mem_load = 32'h55; #1;
        chk("rdy4_dhit", dhit, 1);
        chk("rdy4_err", err, 0);
        chk("rdy4_dload", dload, 32'h55);
        tick(); mem_ready = 1'b0; #1;

        // reset mid-access, then a normal instruction fetch
        dren = 1'b1; daddr = 32'h400; #1;
        tick(); dren = 1'b0; #1;
        chk("mid_ren", mem_ren, 1);
        nrst = 1'b0; mem_ready = 1'b1; #1;
        chk("mid_rst_ren", mem_ren, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_dhit", dhit, 0);
        mem_ready = 1'b0;
        tick(); nrst = 1'b1; iren = 1'b1; iaddr = 32'h500; #1;
        chk("post_rst_idle", mem_ren, 0);
        tick(); iren = 1'b0; mem_ready = 1'b1; mem_load = 32'h77; #1;
        chk("post_rst_addr", mem_addr, 32'h500);
        chk("post_rst_ihit", ihit, 1);
        chk("post_rst_iload", iload, 32'h77);
        tick(); mem_ready = 1'b0; #1;

        // inputs changed after grant are ignored
        iren = 1'b1; iaddr = 32'h600; #1;
        tick(); iren = 1'b0; iaddr = 32'h999; #1;
        chk("lat1_addr", mem_addr, 32'h600);
        chk("lat1_ihit", ihit, 0);
        tick(); mem_ready = 1'b1; mem_load = 32'h88; #1;
        chk("lat2_addr", mem_addr, 32'h600);
        chk("lat2_ihit", ihit, 1);
        tick(); mem_ready = 1'b0; #1;
        chk("lat_idle", mem_ren, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
